// File: rtl/div_seq_ctrl.sv
// Sequential 32-iteration restoring divider controller for RV32M DIV/DIVU/REM/REMU.
// Stalls the front of the pipe while iterating and pulses done with a registered result.
module div_seq_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              iter_done;
  logic              sel_rem;
  logic              q_neg, r_neg;
  logic [XLEN-1:0]   quo, rem, dvs;

  logic              accept, div_zero, ovf, special;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   trial;
  logic              fits;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand decode and special-case detection in IDLE
  always_comb begin
    accept   = (state == IDLE) && start && !flush;
    div_zero = (divisor == '0);
    ovf      = !op[0] && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special  = div_zero || ovf;
    a_neg    = !op[0] && dividend[XLEN-1];
    b_neg    = !op[0] && divisor[XLEN-1];
    a_abs    = a_neg ? (~dividend + XLEN'(1)) : dividend;
    b_abs    = b_neg ? (~divisor + XLEN'(1)) : divisor;
  end

  // One restoring step; the extra top bit keeps the borrow of the 33-bit trial
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    fits    = !trial[XLEN+1];
    quo_fix = q_neg ? (~quo + XLEN'(1)) : quo;
    rem_fix = r_neg ? (~rem + XLEN'(1)) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = special ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush)          state_nx = IDLE;
        else if (iter_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and apply sign fix-up on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      iter_done <= 1'b0;
      sel_rem   <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem   <= op[1];
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            quo       <= a_abs;
            dvs       <= b_abs;
            rem       <= '0;
            cnt       <= '0;
            iter_done <= 1'b0;
            if (div_zero)
              result <= op[1] ? dividend : '1;
            else if (ovf)
              result <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end
        end
        CALC: begin
          if (!flush) begin
            if (iter_done) begin
              result <= sel_rem ? rem_fix : quo_fix;
            end else begin
              rem <= fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], fits};
              cnt <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(XLEN-1)) iter_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
